pulse_meter: RTL

- Downstream consumer of the glitch-filtered input stage; takes its debounced synchronous level output and derives edge and timing measurements.
- Counts rising edges, measures period (rise-to-rise) and high time in clock cycles, and flags loss of signal via a timeout.
- Results feed register readback for encoder/frequency/PWM-input style interfaces.

---
 rtl/pulse_meter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pulse_meter.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_meter
//  Description : Edge and timing meter for a debounced, clk-synchronous level.
//                Counts rising edges, measures rise-to-rise period and the
//                high time of the last completed period (both in clk cycles),
//                and raises a sticky loss-of-signal flag when no rise follows
//                within TIMEOUT cycles.
//  Ports       : clk        - system clock
//                rst        - asynchronous active-high reset
//                din        - filtered level, already synchronous to clk
//                edge_count - rising-edge counter, wraps modulo 2^WIDTH
//                period     - cycles between the last two rises, 0 if invalid
//                high_time  - high cycles of last completed period, 0 if invalid
//                valid      - one-cycle strobe when period/high_time update
//                timeout    - sticky signal-lost flag, cleared by next valid
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_meter #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 50000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   output logic [WIDTH-1:0] edge_count,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             valid,
   output logic             timeout
);

   localparam logic [WIDTH-1:0] c_timeout = WIDTH'(TIMEOUT);
   localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
   localparam logic [WIDTH-1:0] c_zero    = '0;

   typedef enum logic [0:0] {
      ST_WAIT_FIRST = 1'b0,
      ST_MEASURE    = 1'b1
   } state_t;

   state_t           r_state;
   logic             r_din_q;
   logic [WIDTH-1:0] r_per_cnt;
   logic [WIDTH-1:0] r_hi_cnt;
   logic [WIDTH-1:0] r_hi_latched;

   logic w_rise;
   logic w_fall;

   assign w_rise = din & ~r_din_q;
   assign w_fall = ~din & r_din_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_WAIT_FIRST;
         r_din_q      <= 1'b0;
         r_per_cnt    <= c_zero;
         r_hi_cnt     <= c_zero;
         r_hi_latched <= c_zero;
         edge_count   <= c_zero;
         period       <= c_zero;
         high_time    <= c_zero;
         valid        <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         r_din_q <= din;
         valid   <= 1'b0;

         // Edge counting is independent of the measurement state.
         if (w_rise) begin
            edge_count <= edge_count + c_one;
         end

         case (r_state)
            ST_WAIT_FIRST: begin
               // The first rise only opens a measurement window; with no
               // earlier reference there is nothing to report yet.
               if (w_rise) begin
                  r_state      <= ST_MEASURE;
                  r_per_cnt    <= c_one;
                  r_hi_cnt     <= c_one;
                  r_hi_latched <= c_zero;
               end
            end

            ST_MEASURE: begin
               if (w_rise) begin
                  // A rise coinciding with the timeout limit still counts as
                  // a valid measurement of exactly TIMEOUT cycles.
                  period       <= r_per_cnt;
                  high_time    <= r_hi_latched;
                  valid        <= 1'b1;
                  timeout      <= 1'b0;
                  r_per_cnt    <= c_one;
                  r_hi_cnt     <= c_one;
                  r_hi_latched <= c_zero;
               end else if (r_per_cnt == c_timeout) begin
                  // Signal lost: invalidate results and rearm for a fresh
                  // first rise. Timers stop here, so they never overflow.
                  r_state   <= ST_WAIT_FIRST;
                  timeout   <= 1'b1;
                  period    <= c_zero;
                  high_time <= c_zero;
               end else begin
                  r_per_cnt <= r_per_cnt + c_one;
                  if (din) begin
                     r_hi_cnt <= r_hi_cnt + c_one;
                  end
                  // hi_cnt already holds the full high run when the low
                  // level is first seen.
                  if (w_fall) begin
                     r_hi_latched <= r_hi_cnt;
                  end
               end
            end

            default: begin
               r_state <= ST_WAIT_FIRST;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
